mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencer that sits directly upstream of the 16:1 mux. It drives the mux select lines, steps through a latched 16-bit channel mask in ascending order, and samples the mux output once per enabled channel. When the scan ends it publishes all samples as one 16-bit word. This turns the combinational mux into a start/done-handshaked channel scanner for the rest of the design.

## Interface
- DWELL, 1: cycles each selected channel is held on `sel` before sampling (legal 1..255).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a scan; accepted only in IDLE.
- mask  in  16  channel enable; bit i set scans channel i; latched when start is accepted.
- y_in  in  1  mux output (the `y` of the 16:1 mux).
- sel  out  4  mux select (drives the mux `sel`).
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  out  1  single-cycle pulse; result updated in the same cycle.
- result  out  16  bit i = sample of channel i from the last scan; 0 for unmasked channels.

## Operation
- States: IDLE, DWELL, FINISH.
- IDLE:
  - sel=0, busy=0.
  - On start=1, latch mask into mask_q and clear the shadow register.
  - If mask≠0: load sel with the index of the lowest set bit, load the dwell counter with DWELL-1, go to DWELL.
  - If mask=0: go to FINISH.
- DWELL:
  - sel is held, busy=1.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, store y_in into shadow[sel] and clear mask_q[sel] on that edge.
  - If any mask_q bit above sel remains, load sel with the next higher set index and reload the counter with DWELL-1.
  - Otherwise go to FINISH.
- FINISH:
  - For one cycle: done=1, busy=0, result=shadow. The result register loads on the edge entering FINISH.
  - Unconditionally returns to IDLE. A start in FINISH is ignored.
- Unmasked channels are skipped in zero cycles. `sel` never presents an unmasked index while busy.
- result holds its previous value throughout a scan and changes only when done is asserted.
- start while busy or in FINISH is ignored. mask changes after acceptance have no effect.

## Timing
- Reset values: sel=0, busy=0, done=0, result=0, state IDLE, shadow=0, counter=0.
- rst mid-scan aborts on the next edge with all outputs at reset values. No done pulse is produced, and result is cleared.
- Cycle numbering: start is sampled at edge E0. Channel k of N enabled channels (k=0..N-1) is on `sel` during cycles DWELL·k+1 through DWELL·(k+1).
- y_in is sampled at the edge ending the last cycle of each dwell window. The mux is combinational, so y_in must be valid in that same cycle.
- done is high in cycle DWELL·N+1. Total latency from start edge to done is DWELL·N+1 cycles; for mask=0 it is 1 cycle.
- A new start is accepted in the cycle after done (back-to-back scans have one idle cycle).
- With N=16, index 15 is the final channel and `sel` does not wrap to 0 mid-scan.

## Configuration
- MUX_SCAN_PARITY_EN defined: adds output `parity` (1 bit, reset 0). It is loaded with the XOR of all shadow bits on the same edge as result and is stable alongside result.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles with start=1, mask=16'hFFFF. Required: sel=0, busy=0, done=0, result=16'h0000 throughout.
- Full scan, DWELL=1: mask=16'hFFFF with the mux fed a=16'hA5C3. Required: sel steps 0..15 in cycles 1..16, done in cycle 17, result=16'hA5C3; with MUX_SCAN_PARITY_EN, parity=0.
- Sparse mask, DWELL=3: mask=16'h8101 with a=16'hFFFF. Required: sel is 0, 8 and 15 for 3 cycles each, done in cycle 10, result=16'h8101.
- Empty mask: start with mask=16'h0000. Required: done in cycle 1, busy never high, result=16'h0000.
- Ignored start: mask=16'h0003, then start pulses with mask=16'hFFFF while busy and in the done cycle. Required: a single scan of channels 0 and 1 only, and a single done pulse.
- Abort: start with mask=16'hFFFF, rst asserted in cycle 6. Required: the next cycle shows sel=0, busy=0, result=0, and done never pulses; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequences the 16:1 mux select over a latched channel mask and publishes one sample per enabled channel
// Ports: i_clk/i_rst (sync, active-high), i_start + i_mask request a scan, i_y_in is the mux output,
// o_sel drives the mux select, o_busy marks an active scan, o_done pulses with o_result (bit i = channel i sample).
// Optional: define MUX_SCAN_PARITY_EN to add o_parity, the XOR of the published result.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_mask,
  input  logic        i_y_in,
  output logic [3:0]  o_sel,
  output logic        o_busy,
  output logic        o_done,
`ifdef MUX_SCAN_PARITY_EN
  output logic        o_parity,
`endif
  output logic [15:0] o_result
);
  localparam logic [1:0] S_IDLE = 2'd0, S_DWELL = 2'd1, S_FINISH = 2'd2;
  localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);
  logic [1:0]  r_state;
  logic [3:0]  r_sel;
  logic [7:0]  r_cnt;
  logic [15:0] r_mask, r_shadow, r_result;
  logic [15:0] w_shadow_nxt, w_mask_left;
  logic        r_parity;
  function automatic logic [3:0] lowest(input logic [15:0] m);
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) lowest = 4'(i);
  endfunction
  // channels are consumed in ascending order, so the lowest remaining bit is the next channel
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[r_sel] = i_y_in;
    w_mask_left = r_mask;
    w_mask_left[r_sel] = 1'b0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_sel    <= 4'd0;
      r_cnt    <= 8'd0;
      r_mask   <= 16'd0;
      r_shadow <= 16'd0;
      r_result <= 16'd0;
      r_parity <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mask   <= i_mask;
          r_shadow <= 16'd0;
          if (|i_mask) begin
            r_sel   <= lowest(i_mask);
            r_cnt   <= CNT_LOAD;
            r_state <= S_DWELL;
          end else begin
            r_result <= 16'd0;
            r_parity <= 1'b0;
            r_state  <= S_FINISH;
          end
        end
        S_DWELL: if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end else begin
          r_shadow <= w_shadow_nxt;
          r_mask   <= w_mask_left;
          if (|w_mask_left) begin
            r_sel <= lowest(w_mask_left);
            r_cnt <= CNT_LOAD;
          end else begin
            r_sel    <= 4'd0;
            r_result <= w_shadow_nxt;
            r_parity <= ^w_shadow_nxt;
            r_state  <= S_FINISH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_sel    = r_sel;
  assign o_busy   = r_state == S_DWELL;
  assign o_done   = r_state == S_FINISH;
  assign o_result = r_result;
`ifdef MUX_SCAN_PARITY_EN
  assign o_parity = r_parity;
`else
  logic w_unused;
  assign w_unused = r_parity;
`endif
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed scoreboard bench for mux_scan_ctrl at DWELL=1 and DWELL=3
module tb_mux_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [2];
  logic [15:0] mask [2];
  logic [15:0] a_v [2];
  logic        y [2];
  logic [3:0]  sel [2];
  logic        busy [2];
  logic        done [2];
  logic [15:0] result [2];
  logic        parity [2];
  logic [15:0] prev_res [2];
  int checks = 0;
  int errors = 0;
  int q_sel [$];
  logic [15:0] q_res [$];
  always #5 clk = ~clk;
  assign y[0] = a_v[0][sel[0]];
  assign y[1] = a_v[1][sel[1]];
  mux_scan_ctrl #(.DWELL(1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_mask(mask[0]), .i_y_in(y[0]),
    .o_sel(sel[0]), .o_busy(busy[0]), .o_done(done[0]),
`ifdef MUX_SCAN_PARITY_EN
    .o_parity(parity[0]),
`endif
    .o_result(result[0])
  );
  mux_scan_ctrl #(.DWELL(3)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_mask(mask[1]), .i_y_in(y[1]),
    .o_sel(sel[1]), .o_busy(busy[1]), .o_done(done[1]),
`ifdef MUX_SCAN_PARITY_EN
    .o_parity(parity[1]),
`endif
    .o_result(result[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic scan(input int d, input logic [15:0] m, input logic [15:0] a, input logic pulse);
    int dw = (d == 0) ? 1 : 3;
    int cyc = 1;
    int e;
    logic [15:0] r;
    for (int i = 0; i < 16; i++) if (m[i]) repeat (dw) q_sel.push_back(i);
    q_res.push_back(m & a);
    a_v[d] = a;
    mask[d] = m;
    start[d] = 1'b1;
    step();
    start[d] = pulse;
    mask[d] = pulse ? 16'hFFFF : 16'($urandom);
    while (q_sel.size() != 0) begin
      e = q_sel.pop_front();
      chk($sformatf("sel d%0d c%0d", d, cyc), 32'(sel[d]), 32'(e));
      chk($sformatf("busy d%0d c%0d", d, cyc), 32'(busy[d]), 32'd1);
      chk($sformatf("done_low d%0d c%0d", d, cyc), 32'(done[d]), 32'd0);
      chk($sformatf("hold d%0d c%0d", d, cyc), 32'(result[d]), 32'(prev_res[d]));
      step();
      cyc++;
    end
    r = q_res.pop_front();
    chk($sformatf("done d%0d c%0d", d, cyc), 32'(done[d]), 32'd1);
    chk($sformatf("busy_fin d%0d", d), 32'(busy[d]), 32'd0);
    chk($sformatf("result d%0d", d), 32'(result[d]), 32'(r));
`ifdef MUX_SCAN_PARITY_EN
    chk($sformatf("parity d%0d", d), 32'(parity[d]), 32'(^r));
`endif
    prev_res[d] = r;
    step();
    start[d] = 1'b0;
    chk($sformatf("post_done d%0d", d), 32'(done[d]), 32'd0);
    chk($sformatf("post_busy d%0d", d), 32'(busy[d]), 32'd0);
    chk($sformatf("post_sel d%0d", d), 32'(sel[d]), 32'd0);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b1;
      mask[d] = 16'hFFFF;
      a_v[d] = 16'h0000;
      prev_res[d] = 16'h0000;
    end
    repeat (2) begin
      step();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_sel d%0d", d), 32'(sel[d]), 32'd0);
        chk($sformatf("rst_busy d%0d", d), 32'(busy[d]), 32'd0);
        chk($sformatf("rst_done d%0d", d), 32'(done[d]), 32'd0);
        chk($sformatf("rst_result d%0d", d), 32'(result[d]), 32'd0);
      end
    end
    rst = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    step();
    scan(0, 16'hFFFF, 16'hA5C3, 1'b0);
    scan(1, 16'h8101, 16'hFFFF, 1'b0);
    scan(1, 16'h0000, 16'hFFFF, 1'b0);
    scan(0, 16'h0000, 16'h1234, 1'b0);
    scan(0, 16'h0003, 16'h0002, 1'b1);
    repeat (3) begin
      chk("no_rescan_busy", 32'(busy[0]), 32'd0);
      chk("no_rescan_done", 32'(done[0]), 32'd0);
      step();
    end
    scan(1, 16'h6A5C, 16'h3C3C, 1'b0);
    scan(0, 16'hFFFF, 16'hA5C3, 1'b0);
    start[0] = 1'b1;
    mask[0] = 16'hFFFF;
    step();
    start[0] = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_sel", 32'(sel[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_done", 32'(done[0]), 32'd0);
    chk("abort_result", 32'(result[0]), 32'd0);
    prev_res[0] = 16'h0000;
    prev_res[1] = 16'h0000;
    repeat (20) begin
      chk("abort_no_done", 32'(done[0]), 32'd0);
      step();
    end
    scan(0, 16'h00F0, 16'h0030, 1'b0);
    scan(1, 16'h8000, 16'h8000, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
